// File: rtl/param_rr_fifo_arbiter.sv
// Per-channel circular FIFOs feeding one registered output slot.
// A work-conserving round-robin arbiter picks which channel fills the slot.
module param_rr_fifo_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N-1:0]            wen,
    input  logic [N*DATA_W-1:0]     din,
    input  logic                    ready,
    output logic [DATA_W-1:0]       dout,
    output logic                    valid,
    output logic [$clog2(N)-1:0]    grant,
    output logic [N-1:0]            full,
    output logic [N-1:0]            empty,
    output logic [N-1:0]            wr_err
);

    localparam int GW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Handshake: the output slot loads whenever it is empty (valid=0) or the
    // downstream takes the current word (ready=1); otherwise it holds.
    logic [DATA_W-1:0] mem [N][DEPTH];
    logic [PW-1:0]     wr_ptr [N];
    logic [PW-1:0]     rd_ptr [N];
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     sel;
    logic [GW-1:0]     sel_next;
    logic [GW:0]       idx_w;
    logic [GW-1:0]     idx;
    logic              sel_found;
    logic              load;
    logic [N-1:0]      wr_ok;
    logic [N-1:0]      pop;
    logic [DATA_W-1:0] head;

    for (genvar i = 0; i < N; i++) begin : g_flags
        assign empty[i] = (wr_ptr[i] == rd_ptr[i]);
        assign full[i]  = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                          (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
    end

    assign load  = !valid || ready;
    assign wr_ok = wen & ~full;

    // Search rr_ptr, rr_ptr+1, ... mod N for the first non-empty channel.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        idx_w     = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx_w = {1'b0, rr_ptr} + (GW+1)'(k);
            if (idx_w >= (GW+1)'(N)) begin
                idx_w = idx_w - (GW+1)'(N);
            end
            idx = idx_w[GW-1:0];
            if (!sel_found && !empty[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    assign sel_next = (sel == GW'(N-1)) ? '0 : sel + GW'(1);
    assign head     = mem[sel][rd_ptr[sel][AW-1:0]];

    always_comb begin
        pop = '0;
        if (load && sel_found) begin
            pop[sel] = 1'b1;
        end
    end

    // Storage is deliberately not reset; pointer reset alone hides old words.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_ok[i]) begin
                mem[i][wr_ptr[i][AW-1:0]] <= din[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout   <= '0;
            valid  <= 1'b0;
            grant  <= '0;
            rr_ptr <= '0;
            wr_err <= '0;
        end else begin
            wr_err <= wen & full;
            if (load) begin
                if (sel_found) begin
                    dout   <= head;
                    grant  <= sel;
                    valid  <= 1'b1;
                    rr_ptr <= sel_next;
                end else begin
                    dout  <= '0;
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_rr_fifo_arbiter.sv
// Directed bench for param_rr_fifo_arbiter with N=4, DATA_W=8, DEPTH=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_param_rr_fifo_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    wen = '0;
    logic [N*DW-1:0] din = '0;
    logic            ready = 1'b0;
    logic [DW-1:0]   dout;
    logic            valid;
    logic [1:0]      grant;
    logic [N-1:0]    full;
    logic [N-1:0]    empty;
    logic [N-1:0]    wr_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_d [8];
    logic [7:0] exp_h [7];

    param_rr_fifo_arbiter #(.N(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .din    (din),
        .ready  (ready),
        .dout   (dout),
        .valid  (valid),
        .grant  (grant),
        .full   (full),
        .empty  (empty),
        .wr_err (wr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        wen   = '0;
        din   = '0;
        ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_word(input string tag, input logic [7:0] d, input logic [1:0] g);
        check({tag, ".valid"}, valid, 1);
        check({tag, ".dout"}, dout, d);
        check({tag, ".grant"}, grant, g);
    endtask

    // Two simultaneous writes to every channel; the slot loads on the second edge.
    task automatic preload(input string tag, input logic [31:0] first, input logic [31:0] second);
        wen = '1;
        din = first;
        tick();
        check({tag, ".nobypass"}, valid, 0);
        din = second;
        tick();
        wen = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        ready = 1'b1;
        check("rst.valid", valid, 0);
        check("rst.dout", dout, 0);
        check("rst.grant", grant, 0);
        check("rst.empty", empty, 4'hf);
        check("rst.full", full, 0);
        check("rst.wr_err", wr_err, 0);

        // single word latency
        wen = 4'b0001;
        din[7:0] = 8'h11;
        tick();
        wen = '0;
        check("single.nobypass", valid, 0);
        check("single.empty0", empty[0], 0);
        tick();
        check_word("single.out", 8'h11, 2'd0);
        tick();
        check("single.after.valid", valid, 0);
        check("single.after.dout", dout, 0);

        // full rotation
        do_reset();
        ready = 1'b1;
        exp_d = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1, 8'hB1, 8'hC1, 8'hD1};
        preload("rot", {8'hD0, 8'hC0, 8'hB0, 8'hA0}, {8'hD1, 8'hC1, 8'hB1, 8'hA1});
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check_word($sformatf("rot[%0d]", i), exp_d[i], 2'(i % 4));
        end
        tick();
        check("rot.end.valid", valid, 0);
        check("rot.end.empty", empty, 4'hf);

        // skip empty channels starting from rr_ptr=1
        do_reset();
        ready = 1'b1;
        wen = 4'b0001;
        din[7:0] = 8'h01;
        tick();
        wen = '0;
        tick();
        check_word("skip.first", 8'h01, 2'd0);
        wen = 4'b0101;
        din = '0;
        din[7:0]   = 8'h20;
        din[23:16] = 8'h22;
        tick();
        wen = '0;
        check("skip.idle", valid, 0);
        tick();
        check_word("skip.ch2", 8'h22, 2'd2);
        tick();
        check_word("skip.ch0", 8'h20, 2'd0);
        tick();
        check("skip.end.valid", valid, 0);

        // overflow on ch1 while the slot holds a word
        do_reset();
        ready = 1'b0;
        wen = 4'b0001;
        din[7:0] = 8'hEE;
        tick();
        wen = '0;
        tick();
        check_word("ovf.hold", 8'hEE, 2'd0);
        for (int j = 0; j < 9; j++) begin
            wen = 4'b0010;
            din[15:8] = 8'(j);
            tick();
            if (j == 6) check("ovf.notfull", full[1], 0);
            if (j == 7) begin
                check("ovf.full", full[1], 1);
                check("ovf.noerr", wr_err[1], 0);
            end
            if (j == 8) begin
                check("ovf.err", wr_err[1], 1);
                check("ovf.stillfull", full[1], 1);
            end
        end
        wen = '0;
        tick();
        check("ovf.errpulse", wr_err[1], 0);
        check_word("ovf.held", 8'hEE, 2'd0);
        ready = 1'b1;
        wen = 4'b0010;
        din[15:8] = 8'h99;
        tick();
        wen = '0;
        check_word("ovf.drain[0]", 8'h00, 2'd1);
        check("ovf.popnoroom", wr_err[1], 1);
        check("ovf.full.after", full[1], 0);
        for (int j = 1; j < 8; j++) begin
            tick();
            check_word($sformatf("ovf.drain[%0d]", j), 8'(j), 2'd1);
        end
        tick();
        check("ovf.end.valid", valid, 0);
        check("ovf.end.empty1", empty[1], 1);

        // stream through ch3 across pointer wrap
        for (int j = 0; j < 20; j++) begin
            wen = 4'b1000;
            din[31:24] = 8'h30 + 8'(j);
            tick();
            if (j == 0) check("wrap.first.valid", valid, 0);
            else check_word($sformatf("wrap[%0d]", j - 1), 8'h30 + 8'(j - 1), 2'd3);
        end
        wen = '0;
        tick();
        check_word("wrap[19]", 8'h43, 2'd3);
        tick();
        check("wrap.end.valid", valid, 0);

        // backpressure hold then resume
        do_reset();
        ready = 1'b0;
        exp_h = '{8'h61, 8'h62, 8'h63, 8'h68, 8'h69, 8'h6A, 8'h6B};
        preload("bp", {8'h63, 8'h62, 8'h61, 8'h60}, {8'h6B, 8'h6A, 8'h69, 8'h68});
        check_word("bp.load", 8'h60, 2'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_word($sformatf("bp.hold[%0d]", c), 8'h60, 2'd0);
            check($sformatf("bp.hold[%0d].empty", c), empty, 4'h0);
        end
        ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_word($sformatf("bp.resume[%0d]", i), exp_h[i], 2'((i + 1) % 4));
        end
        tick();
        check("bp.end.valid", valid, 0);
        check("bp.end.empty", empty, 4'hf);

        // asynchronous reset mid-stream
        do_reset();
        ready = 1'b1;
        preload("ar", {8'hD0, 8'hC0, 8'hB0, 8'hA0}, {8'hD1, 8'hC1, 8'hB1, 8'hA1});
        tick();
        check_word("ar.pre", 8'hB0, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.valid", valid, 0);
        check("ar.dout", dout, 0);
        check("ar.grant", grant, 0);
        check("ar.empty", empty, 4'hf);
        check("ar.full", full, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("ar.idle[%0d]", c), valid, 0);
        end
        check("ar.empty.after", empty, 4'hf);
        wen = 4'b0100;
        din[23:16] = 8'h77;
        tick();
        wen = '0;
        check("ar.nobypass", valid, 0);
        tick();
        check_word("ar.new", 8'h77, 2'd2);
        tick();
        check("ar.end.valid", valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/param_rr_fifo_arbiter.md
PARAM_RR_FIFO_ARBITER -- requirements
Module: param_rr_fifo_arbiter

Interface
REQ-001 The block SHALL have the following parameters:
  N        4   number of input channels (>=2)
  DATA_W   8   data width per channel
  DEPTH    8   words per channel FIFO (power of 2, >=2)
REQ-002 The block SHALL have the following ports:
  clk     input   1            single clock; all state updates on rising edge
  rst_n   input   1            asynchronous active-low reset
  wen     input   N            per-channel write enable
  din     input   N*DATA_W     channel i data on din[i*DATA_W +: DATA_W]
  ready   input   1            downstream accepts dout this cycle
  dout    output  DATA_W       registered output word
  valid   output  1            registered; dout holds a granted word
  grant   output  clog2(N)     registered index of the channel that supplied dout
  full    output  N            channel FIFO holds DEPTH words
  empty   output  N            channel FIFO holds 0 words
  wr_err  output  N            registered one-cycle pulse; write to full FIFO dropped
REQ-003 The block SHALL use clk as its only clock; rst_n SHALL be asynchronous and active-low.

Function
REQ-004 Each channel SHALL own an independent DEPTH-word circular FIFO with read/write pointers of clog2(DEPTH)+1 bits; the extra MSB distinguishes full from empty.
REQ-005 full[i] and empty[i] SHALL be derived combinationally from the registered pointers only.
REQ-006 A write to channel i SHALL be accepted at an edge iff wen[i]=1 and full[i]=0 before that edge; a pop on the same edge does not make room for the write.
REQ-007 wen[i]=1 with full[i]=1 SHALL drop the word, leave the FIFO unchanged, and set wr_err[i]=1 for exactly the following cycle.
REQ-008 Pointers SHALL wrap modulo 2*DEPTH; FIFO order SHALL be preserved across any number of wraps.
REQ-009 The output slot SHALL load when valid=0 or ready=1; otherwise dout, grant and valid SHALL hold and no FIFO SHALL be popped.
REQ-010 On load, the arbiter SHALL search channels rr_ptr, rr_ptr+1, ... mod N and select the first with empty=0 (work-conserving; empty channels skipped, no idle slot).
REQ-011 On load with a selected channel s: pop head of s, dout<=head, grant<=s, valid<=1, rr_ptr<=(s+1) mod N.
REQ-012 On load with all channels empty: valid<=0, dout<=0, grant and rr_ptr unchanged.
REQ-013 A word written at edge k SHALL NOT be eligible before edge k+1 (no bypass); minimum latency write-edge to valid=1 SHALL be one cycle.
REQ-014 With ready held at 1 and all channels non-empty, valid SHALL stay 1 every cycle and grants SHALL rotate 0,1,...,N-1,0.
REQ-015 Simultaneous write and pop on the same channel SHALL both take effect; occupancy unchanged.
REQ-016 A channel SHALL never be popped while empty; a word SHALL never be output twice or lost except per REQ-007.

Reset
REQ-017 rst_n=0 SHALL immediately, without a clock edge, force: all pointers 0, empty all 1, full all 0, valid 0, dout 0, grant 0, rr_ptr 0, wr_err all 0.
REQ-018 FIFO storage SHALL NOT be reset; contents written before reset SHALL never appear on dout after reset.
REQ-019 Reset asserted mid-stream SHALL discard all queued words and any held output word.

Verification (N=4, DATA_W=8, DEPTH=8)
REQ-020 Reset, ready=1, single write 0x11 to ch0 -> one edge later valid=1, dout=0x11, grant=0; next cycle valid=0, dout=0.
REQ-021 Preload ch0..3 with {0xA0,0xA1},{0xB0,0xB1},{0xC0,0xC1},{0xD0,0xD1}, ready=1 -> 8 consecutive valid cycles: A0,B0,C0,D0,A1,B1,C1,D1; grant 0,1,2,3,0,1,2,3.
REQ-022 rr_ptr=1, only ch0 and ch2 non-empty -> grant=2 then grant=0; no valid=0 bubble between them.
REQ-023 Write 9 words 0x00..0x08 to ch1 with ready=0 -> full[1]=1 after 8th, wr_err[1]=1 one cycle after 9th, drain yields 0x00..0x07 only; then stream 20 words through ch3 -> order kept across wrap.
REQ-024 valid=1, ready=0 for 5 cycles with all FIFOs non-empty -> dout, grant constant, no occupancy change; ready=1 -> rotation resumes from held grant+1.
REQ-025 rst_n low asynchronously between edges mid-stream -> valid=0, dout=0, empty=4'b1111 before next edge; after release, no pre-reset data ever output.
